// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the modulo up/down counter.
// The MOD_COUNTER_STICKY_ERR_EN build option selects a sticky load_err
// flag in mod_counter_core. This package does not depend on that option.
package mod_counter_pkg;

    localparam int MOD_DEFAULT   = 14;
    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } mode_e;

    typedef logic [WIDTH_DEFAULT-1:0] count_t;

    // Next free-running value of a default-sized counter.
    // An out-of-range current value recovers to 0.
    function automatic count_t next_count(count_t cur, mode_e m);
        count_t last;
        last = count_t'(MOD_DEFAULT - 1);
        if (cur > last) begin
            return '0;
        end
        if (m == MODE_UP) begin
            return (cur == last) ? '0 : cur + count_t'(1);
        end
        return (cur == '0) ? last : cur - count_t'(1);
    endfunction

endpackage

// File: rtl/mod_counter_step.sv
// Combinational next-state unit for mod_counter_core.
// It computes the next count, a wrap flag and a range-error flag.
// The arithmetic is carried in WIDTH+1 bits, so MOD = 2**WIDTH compares
// correctly and increments are never silently truncated.
module mod_counter_step
    import mod_counter_pkg::*;
#(
    parameter int MOD   = MOD_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic             load_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] count_in_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o,
    output logic             range_err_o
);

    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0] LAST_W = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

    logic [WIDTH:0] cur_w;
    logic [WIDTH:0] in_w;
    logic [WIDTH:0] next_w;
    logic           wrap;
    logic           err;
    mode_e          dir;

    assign cur_w = {1'b0, cur_i};
    assign in_w  = {1'b0, count_in_i};
    assign dir   = mode_e'(mode_i);

    // Priority: load, then corrupted-state recovery, then count in the selected direction.
    always_comb begin
        next_w = '0;
        wrap   = 1'b0;
        err    = 1'b0;
        if (load_i) begin
            if (in_w >= MOD_W) begin
                next_w = LAST_W;
                err    = 1'b1;
            end else begin
                next_w = in_w;
            end
        end else if (cur_w >= MOD_W) begin
            next_w = '0;
            err    = 1'b1;
        end else if (dir == MODE_UP) begin
            if (cur_w == LAST_W) begin
                next_w = '0;
                wrap   = 1'b1;
            end else begin
                next_w = cur_w + ONE_W;
            end
        end else begin
            if (cur_w == '0) begin
                next_w = LAST_W;
                wrap   = 1'b1;
            end else begin
                next_w = cur_w - ONE_W;
            end
        end
    end

    assign next_o      = next_w[WIDTH-1:0];
    assign wrap_o      = wrap;
    // The extra carry bit of next_w should always be clear.
    // If it is ever set, the value is outside the count range, so it is reported as an error.
    assign range_err_o = err | next_w[WIDTH];

endmodule

// File: rtl/mod_counter_core.sv
// Modulo-MOD up/down counter with parallel load. It also provides
// load range checking, a terminal-count pulse and a saturating wrap-event
// counter. All registers are here; mod_counter_step supplies the next state.
// Build option: define MOD_COUNTER_STICKY_ERR_EN to make load_err hold
// until reset. By default load_err is a single-cycle pulse.
module mod_counter_core
    import mod_counter_pkg::*;
#(
    parameter int MOD   = MOD_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int WRAPW = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             load_err,
    output logic [WRAPW-1:0] wrap_cnt
);

    localparam logic [WRAPW-1:0] WRAP_ONE = WRAPW'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic [WRAPW-1:0] wrap_q, wrap_d;

    logic [WIDTH-1:0] step_next;
    logic             step_wrap;
    logic             step_err;

    mod_counter_step #(
        .MOD   (MOD),
        .WIDTH (WIDTH)
    ) u_step (
        .cur_i       (count_q),
        .load_i      (load),
        .mode_i      (mode),
        .count_in_i  (count_in),
        .next_o      (step_next),
        .wrap_o      (step_wrap),
        .range_err_o (step_err)
    );

    // Next-state selection: tc follows the wrap, and wrap_cnt saturates at all ones.
    always_comb begin
        count_d = step_next;
        tc_d    = step_wrap;
        wrap_d  = wrap_q;
        if (step_wrap && (wrap_q != '1)) begin
            wrap_d = wrap_q + WRAP_ONE;
        end
`ifdef MOD_COUNTER_STICKY_ERR_EN
        err_d = err_q | step_err;
`else
        err_d = step_err;
`endif
    end

    // State registers. Asserting reset clears them at once and discards any pending load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign load_err  = err_q;
    assign wrap_cnt  = wrap_q;

endmodule

// File: doc/mod_counter_core.md
Name: mod_counter_core

Overview:
- Synchronous modulo-MOD up/down counter with parallel load. It sits behind the counter verification interface: it consumes load/mode/count_in from the write driver side and produces count_out for the read monitor side.
- Adds range checking on load data, a terminal-count pulse and a wrap-event counter for scoreboard cross-checks.
- Default build is the MOD-14 (0..13) counter.

Parameters:
- MOD, 14, modulus; count_out sequence is 0..MOD-1; legal range 2..16.
- WIDTH, 4, bit width of count_in/count_out; must satisfy 2**WIDTH >= MOD.
- WRAPW, 8, width of the wrap-event counter.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- load  input  1  parallel load request, sampled at rising edge.
- mode  input  1  count direction: 1 = up, 0 = down.
- count_in  input  WIDTH  load value.
- count_out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- load_err  output  1  registered; high for one cycle after an out-of-range load.
- wrap_cnt  output  WRAPW  number of wrap events since reset, saturating.

Behaviour:
- Reset (reset==0, asynchronous, no clock needed):
  - count_out=0, tc=0, load_err=0, wrap_cnt=0.
  - Reset release is synchronous in effect: the first count/load action occurs at the first rising edge with reset==1.
- Each rising edge with reset==1 has priority load > count. There is no enable; the counter advances every cycle.
- Load, count_in < MOD:
  - count_out <= count_in.
  - tc=0, load_err=0, wrap_cnt unchanged.
- Load, count_in >= MOD (illegal; only reachable when MOD < 2**WIDTH, e.g. 14 or 15 for MOD=14):
  - count_out <= MOD-1 (clamp).
  - load_err=1 for that cycle, tc=0.
- Count up (load==0, mode==1):
  - count_out <= (count_out==MOD-1) ? 0 : count_out+1.
- Count down (load==0, mode==0):
  - count_out <= (count_out==0) ? MOD-1 : count_out-1.
- tc:
  - Asserted in the same cycle count_out takes its wrapped value: 0 after MOD-1 going up, or MOD-1 after 0 going down.
  - Deasserted otherwise.
  - A load never asserts tc, even when the loaded value is 0 or MOD-1.
- wrap_cnt:
  - Increments by 1 whenever tc is set.
  - Saturates at 2**WRAPW-1; no rollover.
- Mode change takes effect on the same edge it is sampled. There is no turnaround cycle; mode toggling every cycle is legal.
- Latency: inputs sampled at edge N are reflected on count_out/tc/load_err after edge N. With the driver's #1 output skew, the monitor sees them at edge N+1 sampling.
- Arithmetic is done in WIDTH+1 bits internally; there is no silent truncation.
- Reset asserted mid-count: all outputs clear immediately; any pending load is discarded.
- Error flag:
  - If count_out is ever >= MOD (unreachable by design), the next edge forces count_out to 0 and pulses load_err.
  - This is a guard against SEU/X-corruption.

Optional Feature:
- MOD_COUNTER_STICKY_ERR_EN
  - Defined: load_err is sticky. Once set, it stays 1 until reset.
  - Not defined: load_err is a single-cycle pulse, as described above.
  - Counting behaviour is identical in both builds.

Decomposition:
- Package mod_counter_pkg:
  - localparam defaults MOD_DEFAULT=14, WIDTH_DEFAULT=4.
  - typedef enum logic {MODE_DOWN=1'b0, MODE_UP=1'b1} mode_e.
  - typedef logic [WIDTH_DEFAULT-1:0] count_t.
  - A function next_count(count_t cur, mode_e m), also used by the reference model in the scoreboard.
- Sub-module mod_counter_step:
  - Purely combinational next-value/wrap-detect/clamp unit.
  - Outputs: next value, wrap flag, range-error flag.
  - The core holds all registers.

Test Plan:
- Reset then up-count: reset=0 for 3 cycles, release, mode=1, load=0 for 16 cycles -> count_out 0,1,...,13,0,1. tc high exactly when count_out becomes 0. wrap_cnt=1.
- Down-count wrap: load count_in=2 then mode=0 for 4 cycles -> count_out 2,1,0,13,12. tc high with 13. wrap_cnt=1.
- Illegal load: load=1, count_in=15 -> count_out=13, load_err=1 for one cycle (stays 1 with MOD_COUNTER_STICKY_ERR_EN), tc=0. Next up-count gives 0 with tc=1.
- Load priority and boundary load: load=1, count_in=13, mode=1 -> count_out=13, tc=0. Next cycle load=0 -> count_out=0, tc=1.
- Mode toggle each cycle from 5: mode 1,0,1,0 -> count_out 6,5,6,5. tc never set, wrap_cnt unchanged.
- Asynchronous reset mid-count: count running at 9, pull reset low between edges -> count_out, tc, wrap_cnt go 0 without a clock edge. On release, counting resumes from 0.
